rom_read_arbiter: RTL

//  Shares one ROM_SOFT_F weight/parameter ROM between NUM_REQ requesters (layer engines / PE groups).

---
 rtl/rom_read_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter that shares one ROM read port between NUM_REQ burst requesters.
// Read data is returned with the owner id and a per-requester completion pulse.
module rom_read_arbiter #(
    parameter  int DATA_WIDTH  = 64,
    parameter  int DATA_DEPTH  = 256,
    parameter  int NUM_REQ     = 4,
    parameter  int LEN_WIDTH   = 9,
    parameter  int ROM_LATENCY = 1,
    localparam int ADDR_WIDTH  = $clog2(DATA_DEPTH),
    localparam int ID_WIDTH    = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] base_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  burst_len,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          busy,
    output logic                          rom_r_en,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_data,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_valid,
    output logic [ID_WIDTH-1:0]           rd_id,
    output logic [NUM_REQ-1:0]            done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic                valid;
        logic                last;
        logic [ID_WIDTH-1:0] id;
    } pipe_t;

    state_t                state;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   cur_id;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  zero_len;
    logic                  issue_last;

    logic [ADDR_WIDTH-1:0] base_slot [NUM_REQ];
    logic [LEN_WIDTH-1:0]  len_slot  [NUM_REQ];
    logic                  pick_valid;
    logic [ID_WIDTH-1:0]   pick_id;
    logic [ADDR_WIDTH-1:0] next_addr;

    pipe_t                 pipe_in;
    pipe_t                 pre_out;
    pipe_t                 pipe_out;
    pipe_t                 pipe_q [ROM_LATENCY];

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_WIDTH-1:0] id);
        logic [NUM_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            base_slot[i] = base_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            len_slot[i]  = burst_len[i*LEN_WIDTH +: LEN_WIDTH];
        end
    end

    // Search starts just after the last winner, so the previous owner ends up last in line.
    // NOTE: every always_comb output gets a default before any condition, so no latch can be inferred.
    always_comb begin
        logic [ID_WIDTH-1:0] idx;
        pick_valid = 1'b0;
        pick_id    = '0;
        idx        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
            if (!pick_valid && req[idx]) begin
                pick_valid = 1'b1;
                pick_id    = idx;
            end
        end
    end

    assign next_addr = (rom_addr == ADDR_WIDTH'(DATA_DEPTH - 1)) ? '0 : rom_addr + 1'b1;

    assign pipe_in  = '{valid: rom_r_en, last: issue_last, id: (rom_r_en ? cur_id : '0)};
    assign pipe_out = pipe_q[ROM_LATENCY-1];

    // done is registered alongside the final pipe stage, so it looks one stage upstream.
    generate
        if (ROM_LATENCY == 1) begin : g_pre_lat1
            assign pre_out = pipe_in;
        end else begin : g_pre_latn
            assign pre_out = pipe_q[ROM_LATENCY-2];
        end
    endgenerate

    // NOTE: the latency pipe is reset because it carries valid bits; a pure data store would not need it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROM_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= pipe_in;
            for (int i = 1; i < ROM_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign rd_valid = pipe_out.valid;
    assign rd_id    = pipe_out.id;
    assign rd_data  = rom_data;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= ID_WIDTH'(NUM_REQ - 1);
            cur_id     <= '0;
            remaining  <= '0;
            zero_len   <= 1'b0;
            issue_last <= 1'b0;
            gnt        <= '0;
            busy       <= 1'b0;
            rom_r_en   <= 1'b0;
            rom_addr   <= '0;
            done       <= '0;
        end else begin
            gnt  <= '0;
            done <= (pre_out.valid && pre_out.last) ? onehot(pre_out.id) : '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        cur_id    <= pick_id;
                        rr_ptr    <= pick_id;
                        gnt       <= onehot(pick_id);
                        busy      <= 1'b1;
                        rom_addr  <= base_slot[pick_id];
                        remaining <= len_slot[pick_id];
                        if (len_slot[pick_id] == '0) begin
                            zero_len <= 1'b1;
                            state    <= DRAIN;
                        end else begin
                            zero_len   <= 1'b0;
                            rom_r_en   <= 1'b1;
                            issue_last <= (len_slot[pick_id] == LEN_WIDTH'(1));
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (remaining > LEN_WIDTH'(1)) begin
                        remaining  <= remaining - 1'b1;
                        rom_addr   <= next_addr;
                        issue_last <= (remaining == LEN_WIDTH'(2));
                    end else begin
                        rom_r_en   <= 1'b0;
                        issue_last <= 1'b0;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave once the final word (or the zero-length done) has been presented.
                    if ((pipe_out.valid && pipe_out.last) || (zero_len && done != '0)) begin
                        busy     <= 1'b0;
                        zero_len <= 1'b0;
                        state    <= IDLE;
                    end else if (zero_len) begin
                        done <= onehot(cur_id);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
